disp_scan_4dig: RTL and testbench
=================================

// Module: disp_scan_4dig
// PURPOSE
//  Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
//  Sits directly upstream of the hex-to-7seg decoder. It latches a 16-bit
//  value and cycles through its nibbles, presenting one nibble per slot on
//  digit[3:0] to the decoder. It drives the matching active-low anode and
//  decimal point, with a one-cycle dead slot between digits to prevent ghosting.
// PARAMETERS
//  DIV    50000  clocks each digit is lit (1 kHz/digit at 50 MHz); legal >= 2
//  CNT_W  16     width of the refresh counter; must satisfy 2^CNT_W >= DIV
// PORTS
//  clk       in   1   single system clock, rising edge
//  rst       in   1   synchronous reset, active-high
//  en        in   1   1 = scan enabled; 0 = all anodes off
//  load      in   1   1-cycle strobe: capture data/dp_in
//  data      in   16  value to display; nibble i shown on digit i (0 = rightmost)
//  dp_in     in   4   decimal point request per digit, active-high
//  blank_lz  in   1   1 = suppress leading-zero digits
//  digit     out  4   nibble to the 7seg decoder X input
//  an        out  4   anode enables, active-low, one-hot-low or 4'b1111
//  dp_n      out  1   decimal point segment, active-low
//  sel       out  2   index of the digit currently selected
// BEHAVIOUR
//  - All outputs are registered. Reset values: digit=0, an=4'b1111,
//    dp_n=1, sel=0. Internal state: disp_q=0, dp_q=0, cnt=0, state=IDLE.
//  - load=1 sets disp_q<=data and dp_q<=dp_in at the next edge. This is
//    independent of state and is honoured while en=0.
//  - FSM states are IDLE, DEAD and SHOW.
//    IDLE: an=1111. If en=1, go to DEAD.
//    DEAD: an=1111 for exactly 1 cycle. At the edge leaving DEAD:
//          state<=SHOW, cnt<=0, digit<=disp_q[4*sel+:4], dp_n<=~dp_q[sel],
//          an<=~(4'b0001<<sel), or 4'b1111 if the digit is blanked.
//    SHOW: cnt increments each cycle. When cnt==DIV-1 (tick): state<=DEAD,
//          an<=4'b1111, sel<=sel+1 (wraps 3->0), cnt<=0.
//  - Priority is rst > en=0 > tick. en=0 in any state forces state<=IDLE
//    and an<=4'b1111 on that edge. sel and cnt hold their values and digit
//    keeps its last value. Re-enabling resumes at the held sel via DEAD.
//  - Steady-state period is DIV+1 clocks per digit and 4*(DIV+1) per frame.
//    Each anode is low for exactly DIV consecutive cycles.
//  - Leading-zero blanking: digit i (i=1..3) is blanked when blank_lz=1 and
//    disp_q nibbles i..3 are all 0. Digit 0 is never blanked. A blanked digit
//    still occupies its time slot and dp_n is forced to 1.
//  - The nibble and dp are sampled only at the DEAD->SHOW edge. A load during
//    SHOW does not change the lit digit until its next slot. If load and the
//    DEAD->SHOW edge coincide, the old disp_q is shown.
//  - A synchronous rst mid-scan returns the block to reset values on that
//    edge. Scanning restarts at digit 0.
// TESTING (DIV=4 unless noted)
//  1 rst held 3 cycles then released, en=0 -> an=1111, dp_n=1, digit=0,
//    sel=0 throughout.
//  2 load data=16'h1234, en=1 -> an sequence 1110(4 clk), 1111(1), 1101(4),
//    1111(1), 1011(4), 1111(1), 0111(4), then wraps to 1110. digit is
//    4,3,2,1 respectively.
//  3 data=16'h0005, blank_lz=1 -> digits 1..3 keep an=1111 for their slots
//    and digit 0 shows 5 with an=1110. With blank_lz=0, all four are lit and
//    digits 1..3 show 0.
//  4 dp_in=4'b0100 -> dp_n=0 only while an=1011, otherwise dp_n=1.
//  5 en dropped mid-slot of digit 2 -> an=1111 on the next edge. On
//    re-enable: 1 DEAD cycle, then an=1011 for 4 cycles.
//  6 load 16'hABCD during digit 0 SHOW -> digit stays at the old nibble
//    until the slot ends and the next slot shows C. rst mid-scan ->
//    an=1111, sel=0 on the next edge.

Source files
------------

// File: rtl/disp_scan_4dig.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// Presents one nibble per slot to the decoder, with a dark dead cycle between digits.
module disp_scan_4dig #(
    parameter int DIV   = 50000,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic [1:0]  sel
);

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        SHOW
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       digit_q, digit_d;
    logic [3:0]       an_q, an_d;
    logic             dp_n_q, dp_n_d;
    logic [15:0]      disp_q, disp_d;
    logic [3:0]       dp_q, dp_d;

    logic [3:0]       nibble;
    logic             blank;
    logic             tick;

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        nibble = disp_q[{sel_q, 2'b00} +: 4];
        blank  = 1'b0;
        case (sel_q)
            2'd1:    blank = blank_lz && (disp_q[15:4]  == 12'h000);
            2'd2:    blank = blank_lz && (disp_q[15:8]  == 8'h00);
            2'd3:    blank = blank_lz && (disp_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
        tick = (cnt_q == LAST);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        digit_d = digit_q;
        an_d    = an_q;
        dp_n_d  = dp_n_q;
        disp_d  = load ? data  : disp_q;
        dp_d    = load ? dp_in : dp_q;

        // Disabling parks the scanner but keeps sel so re-enable resumes in place.
        if (!en) begin
            state_d = IDLE;
            an_d    = 4'b1111;
            dp_n_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = DEAD;
                end
                DEAD: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    digit_d = nibble;
                    if (blank) begin
                        an_d   = 4'b1111;
                        dp_n_d = 1'b1;
                    end else begin
                        an_d   = ~(4'b0001 << sel_q);
                        dp_n_d = ~dp_q[sel_q];
                    end
                end
                SHOW: begin
                    if (tick) begin
                        state_d = DEAD;
                        an_d    = 4'b1111;
                        dp_n_d  = 1'b1;
                        sel_d   = sel_q + 2'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    an_d    = 4'b1111;
                    dp_n_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            digit_q <= 4'h0;
            an_q    <= 4'b1111;
            dp_n_q  <= 1'b1;
            disp_q  <= 16'h0000;
            dp_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            dp_n_q  <= dp_n_d;
            disp_q  <= disp_d;
            dp_q    <= dp_d;
        end
    end

    assign digit = digit_q;
    assign an    = an_q;
    assign dp_n  = dp_n_q;
    assign sel   = sel_q;

endmodule

// File: tb/tb_disp_scan_4dig.sv
// Testbench for disp_scan_4dig: directed scenarios plus random traffic,
// checked against a timeline model of the scan pattern.
module tb_disp_scan_4dig;

    localparam int DIV   = 4;
    localparam int CNT_W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        dp_n;
    logic [1:0]  sel;

    int checks = 0;
    int errors = 0;

    // Reference model: position in the enabled timeline decides slot and phase.
    logic [3:0]  mAn   = 4'b1111;
    logic [3:0]  mDig  = 4'h0;
    logic        mDpn  = 1'b1;
    logic [1:0]  mSel  = 2'd0;
    logic [15:0] mDisp = 16'h0000;
    logic [3:0]  mDp   = 4'h0;
    int          k     = 0;
    logic [1:0]  startSel = 2'd0;

    disp_scan_4dig #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .data     (data),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .digit    (digit),
        .an       (an),
        .dp_n     (dp_n),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    task automatic modelEdge();
        int m, slot, off;
        logic [1:0] d;
        logic blankNow;
        if (rst) begin
            mAn = 4'b1111; mDig = 4'h0; mDpn = 1'b1; mSel = 2'd0;
            mDisp = 16'h0000; mDp = 4'h0; k = 0; startSel = 2'd0;
        end else begin
            if (!en) begin
                mAn = 4'b1111; mDpn = 1'b1; k = 0; startSel = mSel;
            end else begin
                k++;
                if (k == 1) begin
                    mAn = 4'b1111; mDpn = 1'b1; mSel = startSel;
                end else begin
                    m    = k - 2;
                    slot = m / (DIV + 1);
                    off  = m % (DIV + 1);
                    d    = 2'((int'(startSel) + slot) % 4);
                    if (off == 0) begin
                        mSel     = d;
                        mDig     = 4'((mDisp >> (4 * d)) & 16'h000F);
                        blankNow = blank_lz && (d != 2'd0) && ((mDisp >> (4 * d)) == 16'h0000);
                        mAn      = blankNow ? 4'b1111 : ~(4'b0001 << d);
                        mDpn     = blankNow ? 1'b1 : ~mDp[d];
                    end else if (off == DIV) begin
                        mAn  = 4'b1111;
                        mDpn = 1'b1;
                        mSel = d + 2'd1;
                    end
                end
            end
            if (load) begin
                mDisp = data;
                mDp   = dp_in;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; data = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst = 1'b0;
            advance();
            checks++;
            if ({an, digit, dp_n, sel} !== {4'b1111, 4'h0, 1'b1, 2'd0}) begin
                errors++;
                $display("[TB] FAIL reset_state cyc%0d: got an=%b digit=%h dp_n=%b sel=%0d, want an=1111 digit=0 dp_n=1 sel=0",
                         i, an, digit, dp_n, sel);
            end
        end
    endtask

    task automatic test_scan();
        data = 16'h1234; dp_in = 4'h0; load = 1'b1; blank_lz = 1'b0;
        advance();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 2 * 4 * (DIV + 1) + 2; i++) begin
            advance();
            checks++;
            if ({an, digit, dp_n, sel} !== {mAn, mDig, mDpn, mSel}) begin
                errors++;
                $display("[TB] FAIL scan cyc%0d: got an=%b digit=%h dp_n=%b sel=%0d, want an=%b digit=%h dp_n=%b sel=%0d",
                         i, an, digit, dp_n, sel, mAn, mDig, mDpn, mSel);
            end
        end
    endtask

    task automatic test_blanking();
        for (int pass = 0; pass < 2; pass++) begin
            data = 16'h0005; dp_in = 4'b1110; load = 1'b1; blank_lz = (pass == 0);
            for (int i = 0; i < 4 * (DIV + 1) + 3; i++) begin
                advance();
                load = 1'b0;
                checks++;
                if ({an, digit, dp_n, sel} !== {mAn, mDig, mDpn, mSel}) begin
                    errors++;
                    $display("[TB] FAIL blanking blz=%0d cyc%0d: got an=%b digit=%h dp_n=%b sel=%0d, want an=%b digit=%h dp_n=%b sel=%0d",
                             blank_lz, i, an, digit, dp_n, sel, mAn, mDig, mDpn, mSel);
                end
            end
        end
    endtask

    task automatic test_dp();
        data = 16'(($urandom & 32'h7777) | 32'h1000); dp_in = 4'b0100; load = 1'b1; blank_lz = 1'b0;
        for (int i = 0; i < 4 * (DIV + 1) + 3; i++) begin
            advance();
            load = 1'b0;
            checks++;
            if ({an, digit, dp_n, sel} !== {mAn, mDig, mDpn, mSel}) begin
                errors++;
                $display("[TB] FAIL dp cyc%0d: got an=%b digit=%h dp_n=%b sel=%0d, want an=%b digit=%h dp_n=%b sel=%0d",
                         i, an, digit, dp_n, sel, mAn, mDig, mDpn, mSel);
            end
        end
    endtask

    task automatic test_enable_toggle();
        int waited = 0;
        while (!(mSel == 2'd2 && mAn == 4'b1011) && waited < 60) begin
            advance();
            waited++;
        end
        checks++;
        if (!(mSel == 2'd2 && mAn == 4'b1011) || an !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL enable_wait: got an=%b, want an=1011 within 60 cycles", an);
        end
        advance();
        en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) en = 1'b1;
            advance();
            checks++;
            if ({an, digit, dp_n, sel} !== {mAn, mDig, mDpn, mSel}) begin
                errors++;
                $display("[TB] FAIL enable_toggle cyc%0d: got an=%b digit=%h dp_n=%b sel=%0d, want an=%b digit=%h dp_n=%b sel=%0d",
                         i, an, digit, dp_n, sel, mAn, mDig, mDpn, mSel);
            end
        end
    endtask

    task automatic test_load_midslot();
        int waited = 0;
        while (!(mSel == 2'd0 && mAn == 4'b1110) && waited < 60) begin
            advance();
            waited++;
        end
        checks++;
        if (!(mSel == 2'd0 && mAn == 4'b1110) || an !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL load_wait: got an=%b, want an=1110 within 60 cycles", an);
        end
        data = 16'hABCD; load = 1'b1;
        for (int i = 0; i < 14; i++) begin
            advance();
            load = 1'b0;
            rst  = (i == 10);
            checks++;
            if ({an, digit, dp_n, sel} !== {mAn, mDig, mDpn, mSel}) begin
                errors++;
                $display("[TB] FAIL load_midslot cyc%0d: got an=%b digit=%h dp_n=%b sel=%0d, want an=%b digit=%h dp_n=%b sel=%0d",
                         i, an, digit, dp_n, sel, mAn, mDig, mDpn, mSel);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            en   = ($urandom_range(0, 29) != 0);
            load = ($urandom_range(0, 9) == 0);
            data = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            dp_in = 4'($urandom);
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            advance();
            checks++;
            if ({an, digit, dp_n, sel} !== {mAn, mDig, mDpn, mSel}) begin
                errors++;
                $display("[TB] FAIL random cyc%0d: got an=%b digit=%h dp_n=%b sel=%0d, want an=%b digit=%h dp_n=%b sel=%0d",
                         i, an, digit, dp_n, sel, mAn, mDig, mDpn, mSel);
            end
        end
        rst = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blanking();
        test_dp();
        test_enable_toggle();
        test_load_midslot();
        en = 1'b1;
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
